// File: rtl/link_monitor.sv
// link_monitor: 100BASE-TX receive link supervisor.
// Qualifies PMD signal detect, enables the descrambler, waits for lock and
// restarts the descrambler on lock failure or loss.
// Optional build macro: LINK_MONITOR_STATS_EN enables the saturating
// lock-failure counter (fail_count / clear_count). Without it fail_count is 0.
module link_monitor #(
  parameter logic [15:0] STABILIZE_CYCLES = 16'd41250,
  parameter logic [15:0] ACQUIRE_TIMEOUT  = 16'd1250,
  parameter logic [15:0] RESTART_CYCLES   = 16'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal_detect,
  input  logic       locked,
  input  logic       test_mode_req,
  input  logic       clear_count,
  output logic       desc_enable,
  output logic       desc_test_mode,
  output logic       link_status,
  output logic [7:0] fail_count,
  output logic [2:0] state
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned COUNT_W = 8;

  localparam logic [2:0] S_DOWN      = 3'd0;
  localparam logic [2:0] S_STABILIZE = 3'd1;
  localparam logic [2:0] S_ACQUIRE   = 3'd2;
  localparam logic [2:0] S_UP        = 3'd3;
  localparam logic [2:0] S_RESTART   = 3'd4;

  localparam logic [TIMER_W-1:0] STAB_LOAD    = TIMER_W'(STABILIZE_CYCLES - 16'd1);
  localparam logic [TIMER_W-1:0] ACQ_LOAD     = TIMER_W'(ACQUIRE_TIMEOUT - 16'd1);
  localparam logic [TIMER_W-1:0] RESTART_LOAD = TIMER_W'(RESTART_CYCLES - 16'd1);

  logic [2:0]         state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic               test_mode_nxt;
  logic               fail_evt;

  // Next-state, timer and lock-failure decode; loss of signal detect wins.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    test_mode_nxt = desc_test_mode;
    fail_evt      = 1'b0;

    if (!signal_detect) begin
      state_nxt = S_DOWN;
      timer_nxt = STAB_LOAD;
    end else begin
      case (state)
        S_DOWN: begin
          state_nxt = S_STABILIZE;
          timer_nxt = STAB_LOAD;
        end
        S_STABILIZE: begin
          if (timer == '0) begin
            state_nxt = S_ACQUIRE;
            timer_nxt = ACQ_LOAD;
          end else begin
            timer_nxt = timer - TIMER_W'(1);
          end
        end
        S_ACQUIRE: begin
          if (locked) begin
            state_nxt = S_UP;
          end else if (timer == '0) begin
            state_nxt = S_RESTART;
            timer_nxt = RESTART_LOAD;
            fail_evt  = 1'b1;
          end else begin
            timer_nxt = timer - TIMER_W'(1);
          end
        end
        S_UP: begin
          if (!locked) begin
            state_nxt = S_RESTART;
            timer_nxt = RESTART_LOAD;
            fail_evt  = 1'b1;
          end
        end
        S_RESTART: begin
          if (timer == '0) begin
            state_nxt = S_ACQUIRE;
            timer_nxt = ACQ_LOAD;
          end else begin
            timer_nxt = timer - TIMER_W'(1);
          end
        end
        default: begin
          state_nxt = S_DOWN;
          timer_nxt = STAB_LOAD;
        end
      endcase
    end

    // Test mode is captured only when leaving DOWN and dropped on return.
    if (state_nxt == S_DOWN) begin
      test_mode_nxt = 1'b0;
    end else if (state == S_DOWN) begin
      test_mode_nxt = test_mode_req;
    end
  end

  // State, timer and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_DOWN;
      timer          <= '0;
      desc_enable    <= 1'b0;
      desc_test_mode <= 1'b0;
      link_status    <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      desc_enable    <= (state_nxt == S_ACQUIRE) || (state_nxt == S_UP);
      desc_test_mode <= test_mode_nxt;
      link_status    <= (state_nxt == S_UP);
    end
  end

`ifdef LINK_MONITOR_STATS_EN
  // Saturating lock-failure counter; a failure coinciding with clear yields 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_count <= '0;
    end else if (clear_count) begin
      fail_count <= fail_evt ? COUNT_W'(1) : COUNT_W'(0);
    end else if (fail_evt && (fail_count != {COUNT_W{1'b1}})) begin
      fail_count <= fail_count + COUNT_W'(1);
    end
  end
`else
  // Statistics disabled: counter tied off, clear request ignored.
  logic unused_stats;
  assign unused_stats = clear_count ^ fail_evt;
  assign fail_count   = '0;
`endif

endmodule

// File: tb/tb_link_monitor.sv
// Self-checking bench for link_monitor with short timer parameters.
module tb_link_monitor;

  localparam int STAB_N = 8;
  localparam int ACQ_N  = 20;
  localparam int RST_N  = 4;

`ifdef LINK_MONITOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int P_DOWN = 0;
  localparam int P_STAB = 1;
  localparam int P_ACQ  = 2;
  localparam int P_UP   = 3;
  localparam int P_RST  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       signal_detect = 1'b0;
  logic       locked = 1'b0;
  logic       test_mode_req = 1'b0;
  logic       clear_count = 1'b0;
  logic       desc_enable;
  logic       desc_test_mode;
  logic       link_status;
  logic [7:0] fail_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  link_monitor #(
    .STABILIZE_CYCLES(16'd8),
    .ACQUIRE_TIMEOUT (16'd20),
    .RESTART_CYCLES  (16'd4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .signal_detect (signal_detect),
    .locked        (locked),
    .test_mode_req (test_mode_req),
    .clear_count   (clear_count),
    .desc_enable   (desc_enable),
    .desc_test_mode(desc_test_mode),
    .link_status   (link_status),
    .fail_count    (fail_count),
    .state         (state)
  );

  always #5 clk = ~clk;

  function automatic int exp_fc(input int n);
    if (!STATS) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: phases timed by elapsed cycles since phase entry.
  int m_phase = P_DOWN;
  int m_fails = 0;
  bit m_tm    = 1'b0;
  int m_cyc   = 0;
  int m_entry = 0;

  always @(posedge clk or negedge rst_n) begin
    int  nxt;
    bit  fail;
    if (!rst_n) begin
      m_phase = P_DOWN;
      m_fails = 0;
      m_tm    = 1'b0;
      m_entry = m_cyc;
    end else begin
      m_cyc++;
      fail = 1'b0;
      nxt  = m_phase;
      if (!signal_detect) nxt = P_DOWN;
      else begin
        case (m_phase)
          P_DOWN: nxt = P_STAB;
          P_STAB: if (m_cyc - m_entry == STAB_N) nxt = P_ACQ;
          P_ACQ: begin
            if (locked) nxt = P_UP;
            else if (m_cyc - m_entry == ACQ_N) begin
              nxt  = P_RST;
              fail = 1'b1;
            end
          end
          P_UP: if (!locked) begin
            nxt  = P_RST;
            fail = 1'b1;
          end
          default: if (m_cyc - m_entry == RST_N) nxt = P_ACQ;
        endcase
      end
      if (nxt == P_DOWN) m_tm = 1'b0;
      else if (m_phase == P_DOWN) m_tm = test_mode_req;
      if (clear_count) m_fails = fail ? 1 : 0;
      else if (fail) m_fails++;
      if (nxt != m_phase) m_entry = m_cyc;
      m_phase = nxt;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("cmp_state", int'(state), m_phase);
      chk("cmp_desc_enable", int'(desc_enable), int'(m_phase == P_ACQ || m_phase == P_UP));
      chk("cmp_link_status", int'(link_status), int'(m_phase == P_UP));
      chk("cmp_desc_test_mode", int'(desc_test_mode), int'(m_tm));
      chk("cmp_fail_count", int'(fail_count), exp_fc(m_fails));
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    tick(2);
    chk("rst_state", int'(state), 0);
    chk("rst_fail", int'(fail_count), 0);
    chk("rst_en", int'(desc_enable), 0);
    rst_n = 1'b1;
    tick(1);
    chk("idle_state", int'(state), 0);

    // Bring-up with test mode requested at the DOWN->STABILIZE edge.
    signal_detect = 1'b1;
    test_mode_req = 1'b1;
    tick(1);
    chk("bu_state_stab", int'(state), 1);
    chk("bu_tm", int'(desc_test_mode), 1);
    test_mode_req = 1'b0;
    tick(7);
    chk("bu_stab_end_state", int'(state), 1);
    chk("bu_stab_end_en", int'(desc_enable), 0);
    tick(1);
    chk("bu_acq_state", int'(state), 2);
    chk("bu_acq_en", int'(desc_enable), 1);
    tick(4);
    locked = 1'b1;
    tick(1);
    chk("bu_up_link", int'(link_status), 1);
    chk("bu_up_state", int'(state), 3);
    chk("bu_up_fail", int'(fail_count), 0);

    // Lock loss in UP.
    locked = 1'b0;
    tick(1);
    chk("ll_link", int'(link_status), 0);
    chk("ll_en", int'(desc_enable), 0);
    chk("ll_state", int'(state), 4);
    chk("ll_fail", int'(fail_count), exp_fc(1));
    tick(3);
    chk("ll_restart_hold", int'(state), 4);
    tick(1);
    chk("ll_reacq", int'(state), 2);
    chk("ll_tm_kept", int'(desc_test_mode), 1);

    // Acquire timeouts with locked held low.
    tick(19);
    chk("to1_pre", int'(state), 2);
    tick(1);
    chk("to1_state", int'(state), 4);
    chk("to1_en", int'(desc_enable), 0);
    chk("to1_fail", int'(fail_count), exp_fc(2));
    tick(4);
    chk("to1_reacq_en", int'(desc_enable), 1);
    tick(20);
    chk("to2_state", int'(state), 4);
    chk("to2_fail", int'(fail_count), exp_fc(3));

    // Signal loss from RESTART clears test mode, keeps the count.
    signal_detect = 1'b0;
    tick(1);
    chk("sl_rst_state", int'(state), 0);
    chk("sl_rst_tm", int'(desc_test_mode), 0);
    chk("sl_rst_fail", int'(fail_count), exp_fc(3));

    // Signal loss in STABILIZE, then a one-cycle glitch forcing a full restart.
    signal_detect = 1'b1;
    tick(3);
    signal_detect = 1'b0;
    tick(1);
    chk("sl_stab_state", int'(state), 0);
    signal_detect = 1'b1;
    tick(1);
    signal_detect = 1'b0;
    tick(1);
    chk("glitch_down", int'(state), 0);
    signal_detect = 1'b1;
    tick(8);
    chk("glitch_full_stab", int'(state), 1);
    tick(1);
    chk("glitch_acq", int'(state), 2);
    signal_detect = 1'b0;
    tick(1);
    chk("sl_acq_state", int'(state), 0);
    chk("sl_acq_en", int'(desc_enable), 0);
    chk("sl_acq_fail", int'(fail_count), exp_fc(3));

    // Signal loss in UP.
    signal_detect = 1'b1;
    tick(9);
    locked = 1'b1;
    tick(1);
    chk("sl_up_pre", int'(state), 3);
    signal_detect = 1'b0;
    tick(1);
    chk("sl_up_state", int'(state), 0);
    chk("sl_up_link", int'(link_status), 0);
    chk("sl_up_fail", int'(fail_count), exp_fc(3));
    locked = 1'b0;

    // Clear in the same cycle as a timeout failure, then clear alone.
    signal_detect = 1'b1;
    tick(9);
    tick(19);
    clear_count = 1'b1;
    tick(1);
    chk("clr_fail_state", int'(state), 4);
    chk("clr_fail_count", int'(fail_count), exp_fc(1));
    tick(1);
    chk("clr_only_count", int'(fail_count), 0);
    clear_count = 1'b0;
    tick(3);
    chk("sat_start_state", int'(state), 2);

    // 260 lock losses saturate the counter.
    for (int i = 0; i < 260; i++) begin
      locked = 1'b1;
      tick(1);
      locked = 1'b0;
      tick(5);
    end
    chk("sat_count", int'(fail_count), exp_fc(260));
    chk("sat_state", int'(state), 2);

    // Asynchronous reset mid-UP.
    locked = 1'b1;
    tick(1);
    chk("ar_pre_up", int'(state), 3);
    rst_n = 1'b0;
    #1;
    chk("ar_state", int'(state), 0);
    chk("ar_link", int'(link_status), 0);
    chk("ar_en", int'(desc_enable), 0);
    chk("ar_fail", int'(fail_count), 0);
    tick(1);
    chk("ar_hold_state", int'(state), 0);
    rst_n = 1'b1;
    #1;
    chk("ar_release_state", int'(state), 0);
    tick(1);
    chk("ar_first_edge", int'(state), 1);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_monitor.md
# link_monitor

Supervises the 100BASE-TX receive path between the PMD signal detect and the descrambler. It qualifies signal detect with a stabilize timer, then enables the descrambler and waits for it to lock. A descrambler that fails to lock, or loses lock, is restarted. The block drives `link_status` to the PCS/MII side and keeps a saturating count of lock failures for management.

## Interface
Parameters:
- `STABILIZE_CYCLES`, 16'd41250, cycles signal detect must stay high before acquisition (330 us at 125 MHz); ≥1.
- `ACQUIRE_TIMEOUT`, 16'd1250, cycles allowed for the descrambler to lock (10 us); ≥1.
- `RESTART_CYCLES`, 16'd16, cycles the descrambler is held disabled on restart; ≥1.

Ports:
- `clk` input 1: receive clock, 125 MHz.
- `rst_n` input 1: reset, asynchronous and active-low.
- `signal_detect` input 1: PMD signal detect, already synchronized to `clk`.
- `locked` input 1: descrambler lock indication.
- `test_mode_req` input 1: requests the descrambler's short unlock timer.
- `clear_count` input 1: synchronous clear of `fail_count`.
- `desc_enable` output 1: drives the descrambler `signal_status`.
- `desc_test_mode` output 1: drives the descrambler `test_mode`.
- `link_status` output 1: link up.
- `fail_count` output 8: saturating count of lock failures.
- `state` output 3: current state, for debug (DOWN=0, STABILIZE=1, ACQUIRE=2, UP=3, RESTART=4).

## Operation
- FSM states: DOWN, STABILIZE, ACQUIRE, UP, RESTART. There is one 16-bit down-counter, `timer`.
- **Priority rule, all states:** if `signal_detect` is 0, the next state is DOWN. This overrides every other transition.
- DOWN:
  - When `signal_detect` is 1, go to STABILIZE.
  - Load `timer` = `STABILIZE_CYCLES`-1.
  - Latch `desc_test_mode` = `test_mode_req`.
- STABILIZE:
  - When `timer` == 0, go to ACQUIRE and load `timer` = `ACQUIRE_TIMEOUT`-1.
  - Otherwise decrement `timer`.
- ACQUIRE:
  - When `locked` is 1, go to UP.
  - When `timer` == 0 with `locked` 0, go to RESTART, load `timer` = `RESTART_CYCLES`-1, and count a failure.
  - Otherwise decrement `timer`. `locked` wins over timer expiry in the same cycle.
- UP: when `locked` is 0, go to RESTART, load `RESTART_CYCLES`-1, and count a failure.
- RESTART: when `timer` == 0, go to ACQUIRE and load `ACQUIRE_TIMEOUT`-1. Otherwise decrement `timer`.
- Outputs are decoded from the next state and registered:
  - `desc_enable` = 1 in ACQUIRE and UP.
  - `link_status` = 1 in UP only.
- `desc_test_mode` changes only on the DOWN→STABILIZE transition. It is cleared on entry to DOWN.
- `fail_count`:
  - Increments by 1 and saturates at 255.
  - `clear_count` sets it to 0.
  - If `clear_count` and a failure occur in the same cycle, the result is 1.
  - Drops to DOWN caused by `signal_detect` never count.
- `timer` never underflows. It is only decremented when nonzero.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - `state`=DOWN, `timer`=0.
  - `desc_enable`=0, `desc_test_mode`=0, `link_status`=0, `fail_count`=0.
- Transition latency: an input sampled at edge N changes `state` and all outputs at edge N (registered from next state). Outputs are therefore visible in the cycle after the input was presented.
- STABILIZE lasts exactly `STABILIZE_CYCLES` cycles. RESTART lasts exactly `RESTART_CYCLES` cycles. ACQUIRE lasts at most `ACQUIRE_TIMEOUT` cycles.
- `link_status` rises at the same edge that samples `locked`=1 in ACQUIRE. It falls at the same edge that samples `locked`=0 in UP, or `signal_detect`=0.
- `desc_enable` is low for at least `RESTART_CYCLES` consecutive cycles on every restart, which guarantees the descrambler clears its LFSR and lock.
- A `signal_detect` glitch of one cycle during STABILIZE forces DOWN and a full new stabilize period.
- Deasserting `rst_n` mid-operation aborts immediately with no counter update. Release is synchronous-safe: the first evaluation happens at the first edge after release.

## Configuration
- Macro `LINK_MONITOR_STATS_EN`.
- Defined: `fail_count` and `clear_count` behave as above.
- Undefined: the counter logic is omitted and `fail_count` is tied to 8'd0. `clear_count` is ignored. The ports remain present and the FSM is unchanged.

## Test plan
All scenarios use `STABILIZE_CYCLES`=8, `ACQUIRE_TIMEOUT`=20, `RESTART_CYCLES`=4, and `LINK_MONITOR_STATS_EN` defined unless noted.
- **Reset:** assert `rst_n`=0 mid-UP → all outputs 0 and `state`=0 asynchronously. They hold until the first edge after release.
- **Bring-up:** `signal_detect`=1 sampled at edge 0 → `state`=1 at edge 0, `desc_enable`=1 at edge 8. With `locked`=1 at edge 13, `link_status`=1 at edge 13 and `fail_count`=0.
- **Acquire timeout:** `locked` held 0.
  - `desc_enable` falls at edge 28 with `fail_count`=1, and rises again at edge 32.
  - The second timeout is at edge 52 with `fail_count`=2.
- **Lock loss in UP:** drop `locked` → `link_status`=0 and `desc_enable`=0 at that edge, and `fail_count` increments. The block re-enters ACQUIRE 4 cycles later.
- **Signal loss:** `signal_detect`=0 during STABILIZE, ACQUIRE and UP → DOWN at that edge, all outputs 0 except `fail_count`, which is unchanged.
  - Set `test_mode_req`=1 only at bring-up → `desc_test_mode`=1 until DOWN.
- **Counter limits:**
  - Force 260 failures → `fail_count`=255.
  - Assert `clear_count` in a failure cycle → `fail_count`=1.
  - With the macro undefined → `fail_count`=0 throughout.
